// File: rtl/tap_loc_pkg.sv
// Shared widths, walk-state encoding and packet layout for the tapping-location scheduler.
package tap_loc_pkg;
    localparam int N_OBJ                = 4;
    localparam int OBJ_ID_WIDTH         = 2;
    localparam int DELAY_LENGTH         = 14;
    localparam int SAMPLE_ADDRESS_WIDTH = 10;
    localparam int ID_WIDTH             = DELAY_LENGTH - SAMPLE_ADDRESS_WIDTH;
    localparam int SCEN_LEN_WIDTH       = 13;
    localparam int PACKET_WIDTH         = SAMPLE_ADDRESS_WIDTH + OBJ_ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } walk_state_t;

    typedef struct packed {
        logic [OBJ_ID_WIDTH-1:0]         obj_id;
        logic [SAMPLE_ADDRESS_WIDTH-1:0] sample_addr;
    } tap_packet_t;

    typedef logic [ID_WIDTH-1:0] tap_dest_id_t;

    // Delays shorter than the hardware latency clamp to zero instead of wrapping.
    function automatic logic [DELAY_LENGTH-1:0] sub_latency(
        input logic [DELAY_LENGTH-1:0] delay,
        input logic [DELAY_LENGTH-1:0] latency
    );
        return (delay < latency) ? '0 : delay - latency;
    endfunction
endpackage

// File: rtl/tap_loc_scen_counter.sv
// Free-running scenario position counter; flags the last cycle of every scenario.
module tap_loc_scen_counter
    import tap_loc_pkg::*;
(
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SCEN_LEN_WIDTH-1:0] scenario_len,
    output logic [SCEN_LEN_WIDTH-1:0] scenario_counter,
    output logic                      scenario_update
);
    logic                      running;
    logic [SCEN_LEN_WIDTH-1:0] count;
    logic [SCEN_LEN_WIDTH-1:0] last_count;

    // Lengths of 0 and 1 both collapse to a one-cycle scenario.
    assign last_count = (scenario_len <= SCEN_LEN_WIDTH'(1)) ? '0
                                                             : scenario_len - SCEN_LEN_WIDTH'(1);

    assign scenario_update  = running && (count == last_count);
    assign scenario_counter = count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (running) begin
            count <= scenario_update ? '0 : count + SCEN_LEN_WIDTH'(1);
        end
    end
endmodule

// File: rtl/tap_loc_scheduler.sv
// Shadow/active delay tables and the walk that turns active delays into tapping-location packets.
module tap_loc_scheduler
    import tap_loc_pkg::*;
(
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      glob_scen_noc_input_valid,
    input  logic [DELAY_LENGTH-1:0]   delay_matrix_element,
    input  logic [OBJ_ID_WIDTH-1:0]   obj_id_element,
    input  logic [DELAY_LENGTH-1:0]   hardware_latency,
    input  logic [SCEN_LEN_WIDTH-1:0] scenario_len,
    input  logic                      start,
    output logic [SCEN_LEN_WIDTH-1:0] scenario_counter,
    output logic                      scenario_update,
    output logic                      tapping_loc_valid,
    input  logic                      tapping_loc_ready,
    output logic [PACKET_WIDTH-1:0]   tapping_loc_packet,
    output logic [ID_WIDTH-1:0]       tap_dest_id,
    output logic                      busy,
    output logic                      underflow_err,
    output logic                      overrun_err
);
    // state | meaning
    // IDLE  | no walk in progress, waiting for a commit
    // SCAN  | stepping idx over active entries looking for a valid one
    // SEND  | packet registered and presented until the consumer takes it

    logic [DELAY_LENGTH-1:0] shadow_delay [N_OBJ];
    logic [DELAY_LENGTH-1:0] active_delay [N_OBJ];
    logic [N_OBJ-1:0]        shadow_v;
    logic [N_OBJ-1:0]        active_v;
    logic                    commit;

    walk_state_t               state, state_nxt;
    logic [OBJ_ID_WIDTH-1:0]   idx, idx_nxt;
    logic                      pending, pending_nxt;
    tap_packet_t               pkt, pkt_nxt;
    tap_dest_id_t              dest, dest_nxt;
    logic                      underflow_nxt, overrun_nxt;
    logic                      next_found;
    logic [OBJ_ID_WIDTH-1:0]   next_idx;
    logic                      load;
    logic [OBJ_ID_WIDTH-1:0]   load_idx;
    logic [DELAY_LENGTH-1:0]   load_delay;
    logic [DELAY_LENGTH-1:0]   adj;

    tap_loc_scen_counter u_scen_counter (
        .CLK              (CLK),
        .reset            (reset),
        .start            (start),
        .scenario_len     (scenario_len),
        .scenario_counter (scenario_counter),
        .scenario_update  (scenario_update)
    );

    assign commit = start | scenario_update;

    // Commit copies the pre-edge shadow, so a same-cycle write only reaches shadow.
    always_ff @(posedge CLK) begin
        if (reset) begin
            shadow_v <= '0;
            active_v <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_delay[i] <= '0;
                active_delay[i] <= '0;
            end
        end else begin
            if (commit) begin
                active_v <= shadow_v;
                for (int i = 0; i < N_OBJ; i++) begin
                    active_delay[i] <= shadow_delay[i];
                end
            end
            if (glob_scen_noc_input_valid) begin
                shadow_delay[obj_id_element] <= delay_matrix_element;
                shadow_v[obj_id_element]     <= 1'b1;
            end
        end
    end

    // Lowest valid entry above idx, so consecutive packets go out without a bubble.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (active_v[i] && (i > int'(idx))) begin
                next_found = 1'b1;
                next_idx   = OBJ_ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pending_nxt   = pending;
        pkt_nxt       = pkt;
        dest_nxt      = dest;
        underflow_nxt = underflow_err;
        overrun_nxt   = overrun_err | (commit & (state != IDLE));
        load          = 1'b0;
        load_idx      = idx;

        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (commit) begin
                    idx_nxt = '0;
                end else if (active_v[idx]) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end else if (idx == OBJ_ID_WIDTH'(N_OBJ - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + OBJ_ID_WIDTH'(1);
                end
            end
            SEND: begin
                if (tapping_loc_ready) begin
                    pending_nxt = 1'b0;
                    if (commit || pending) begin
                        state_nxt = SCAN;
                        idx_nxt   = '0;
                    end else if (next_found) begin
                        load     = 1'b1;
                        load_idx = next_idx;
                        idx_nxt  = next_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (commit) begin
                    // Hold the in-flight packet; restart the walk once it is taken.
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        load_delay = active_delay[load_idx];
        adj        = sub_latency(load_delay, hardware_latency);
        if (load) begin
            pkt_nxt.obj_id      = load_idx;
            pkt_nxt.sample_addr = adj[SAMPLE_ADDRESS_WIDTH-1:0];
            dest_nxt            = adj[DELAY_LENGTH-1:SAMPLE_ADDRESS_WIDTH];
            if (load_delay < hardware_latency) begin
                underflow_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            pending       <= 1'b0;
            pkt           <= '0;
            dest          <= '0;
            underflow_err <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            pending       <= pending_nxt;
            pkt           <= pkt_nxt;
            dest          <= dest_nxt;
            underflow_err <= underflow_nxt;
            overrun_err   <= overrun_nxt;
        end
    end

    assign tapping_loc_valid  = (state == SEND);
    assign busy               = (state != IDLE);
    assign tapping_loc_packet = pkt;
    assign tap_dest_id        = dest;
endmodule
